// File: rtl/saradc_host.sv
// SAR ADC host controller: drives the converter start/end handshake and buffers
// 5-bit results in a small FIFO with sticky overflow/timeout flags.
module saradc_host #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     single,
    input  logic [7:0]               period,
    input  logic                     nEndCnv,
    input  logic [4:0]               dataIn,
    output logic                     nStartCnv,
    input  logic                     rdEn,
    output logic [4:0]               rdData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow,
    output logic                     timeout,
    input  logic                     clearFlags
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]  TMAX     = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {sIdle, sStart, sBusy, sGap} state_e;

    state_e        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [7:0]    gap_q, gap_d;
    logic          pending_q, pending_d;
    logic          nstart_q, nstart_d;
    logic          push_req, abort, enter_start;

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [4:0]    rddata_q, rddata_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic          push, pop, ovf_event;

    // Conversion sequencer; the timer counts cycles spent in sStart or sBusy.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        push_req    = 1'b0;
        abort       = 1'b0;
        enter_start = 1'b0;
        unique case (state_q)
            sIdle: begin
                if (enable || pending_q) state_d = sStart;
            end
            sStart: begin
                if (nEndCnv) begin
                    state_d = sBusy;
                end else if (timer_q == TMAX) begin
                    abort   = 1'b1;
                    state_d = sGap;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            sBusy: begin
                if (!nEndCnv) begin
                    push_req = 1'b1;
                    state_d  = sGap;
                end else if (timer_q == TMAX) begin
                    abort   = 1'b1;
                    state_d = sGap;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            sGap: begin
                if (gap_q == 8'd0) begin
                    state_d = enable ? sStart : sIdle;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = sIdle;
        endcase

        if (state_d == sStart && state_q != sStart) begin
            enter_start = 1'b1;
            timer_d     = 8'd0;
        end
        if (state_d == sBusy && state_q != sBusy) timer_d = 8'd0;
        if (state_d == sGap && state_q != sGap) gap_d = period;

        nstart_d  = (state_d != sStart);
        // A single arriving on the entry edge is kept as a fresh request.
        pending_d = single | (pending_q & ~enter_start);
    end

    // FIFO: a pop frees a slot in the same cycle, so push+pop while full is legal.
    always_comb begin
        pop        = rdEn && (count_q != '0);
        push       = push_req && ((count_q != FULL_CNT) || pop);
        ovf_event  = push_req && (count_q == FULL_CNT) && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rddata_d   = rddata_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rddata_d = mem[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        overflow_d = clearFlags ? 1'b0 : (overflow_q | ovf_event);
        timeout_d  = clearFlags ? 1'b0 : (timeout_q | abort);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= sIdle;
            timer_q    <= 8'd0;
            gap_q      <= 8'd0;
            pending_q  <= 1'b0;
            nstart_q   <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rddata_q   <= 5'd0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            nstart_q   <= nstart_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rddata_q   <= rddata_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // Storage is not reset; occupancy and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= dataIn;
    end

    assign nStartCnv = nstart_q;
    assign rdData    = rddata_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign busy      = (state_q != sIdle);
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_saradc_host.sv
// Bench for saradc_host: converter model, queue-based FIFO reference, vector
// table, directed corner sequences and a randomized run.
module tb_saradc_host;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 40;
    localparam int W_IDLE = 0, W_COUNT = 1, W_NSTART = 2, W_OVF = 3;

    logic       clock, reset, enable, single, nEndCnv, rdEn, clearFlags;
    logic [7:0] period;
    logic [4:0] dataIn, rdData;
    logic       nStartCnv, empty, full, busy, overflow, timeout;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    saradc_host #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .enable(enable), .single(single),
        .period(period), .nEndCnv(nEndCnv), .dataIn(dataIn), .nStartCnv(nStartCnv),
        .rdEn(rdEn), .rdData(rdData), .empty(empty), .full(full), .count(count),
        .busy(busy), .overflow(overflow), .timeout(timeout), .clearFlags(clearFlags)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Converter model: cv_rise/cv_len of 0 pick random timings per conversion.
    int unsigned cv_rise = 1, cv_len = 1;
    bit          cv_dead = 1'b0;
    logic [4:0]  cv_arr [32];
    int unsigned cv_wr = 0, cv_rd = 0;
    int unsigned push_tag = 0;
    logic [4:0]  push_val = 5'd0;

    initial begin : converter
        int unsigned phase, cnt, lim;
        phase = 0; cnt = 0; lim = 0;
        nEndCnv = 1'b0;
        dataIn  = 5'd0;
        forever begin
            @(posedge clock);
            #3;
            if (!reset) begin
                phase   = 0;
                nEndCnv = 1'b0;
            end else begin
                case (phase)
                    0: if (!nStartCnv && !cv_dead) begin
                        phase = 1;
                        cnt   = 1;
                        lim   = (cv_rise != 0) ? cv_rise : $urandom_range(1, 3);
                    end
                    1: if (cnt >= lim) begin
                        nEndCnv = 1'b1;
                        phase   = 2;
                        cnt     = 1;
                        lim     = (cv_len != 0) ? cv_len : $urandom_range(1, 6);
                    end else cnt++;
                    2: if (cnt >= lim) begin
                        nEndCnv = 1'b0;
                        if (cv_rd != cv_wr) begin
                            dataIn = cv_arr[cv_rd[4:0]];
                            cv_rd++;
                        end else begin
                            dataIn = 5'($urandom_range(0, 31));
                        end
                        push_val = dataIn;
                        push_tag++;
                        phase = 0;
                    end else cnt++;
                    default: phase = 0;
                endcase
            end
        end
    end

    // Reference: a plain queue; each converter result is offered on the next edge.
    logic [4:0]  mq [$];
    logic [4:0]  m_rd;
    bit          m_ovf;
    int unsigned seen_tag;

    task automatic ref_reset();
        mq.delete();
        m_rd     = 5'd0;
        m_ovf    = 1'b0;
        seen_tag = push_tag;
    endtask

    task automatic ref_step();
        bit drop;
        drop = 1'b0;
        if (!reset) begin
            ref_reset();
        end else begin
            if (rdEn && mq.size() != 0) m_rd = mq.pop_front();
            if (push_tag != seen_tag) begin
                seen_tag = push_tag;
                if (mq.size() < DEPTH) mq.push_back(push_val);
                else drop = 1'b1;
            end
            if (clearFlags) m_ovf = 1'b0;
            else if (drop) m_ovf = 1'b1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_check();
        chk("model rdData", int'(rdData), int'(m_rd));
        chk("model count", int'(count), mq.size());
        chk("model empty", int'(empty), int'(mq.size() == 0));
        chk("model full", int'(full), int'(mq.size() == DEPTH));
        chk("model overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic tick();
        @(negedge clock);
        ref_step();
        @(posedge clock);
        #1;
        model_check();
    endtask

    function automatic bit cond(input int sel, input int arg);
        case (sel)
            W_IDLE:   return busy == 1'b0;
            W_COUNT:  return int'(count) == arg;
            W_NSTART: return int'(nStartCnv) == arg;
            default:  return overflow == 1'b1;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int arg, input int bound);
        int n = 0;
        while (!cond(sel, arg) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (!cond(sel, arg)) begin
            errors++;
            $display("FAIL wait %s: condition still false after %0d cycles, required true",
                     name, bound);
        end
    endtask

    task automatic load(input logic [4:0] v);
        cv_arr[cv_wr[4:0]] = v;
        cv_wr++;
    endtask

    task automatic pulse_single();
        single = 1'b1;
        tick();
        single = 1'b0;
    endtask

    typedef struct {
        logic [4:0] data;
        bit         pop;
        logic [4:0] exp_rd;
        int         exp_cnt;
        bit         exp_ovf;
    } vec_t;
    vec_t vecs [8];

    logic [4:0] exp4 [4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned tag0;
        int          n;
        bit          ok;

        vecs[0] = '{5'd3,  1'b0, 5'd22, 1, 1'b0};
        vecs[1] = '{5'd7,  1'b1, 5'd3,  1, 1'b0};
        vecs[2] = '{5'd31, 1'b0, 5'd3,  2, 1'b0};
        vecs[3] = '{5'd0,  1'b0, 5'd3,  3, 1'b0};
        vecs[4] = '{5'd17, 1'b0, 5'd3,  4, 1'b0};
        vecs[5] = '{5'd9,  1'b0, 5'd3,  4, 1'b1};
        vecs[6] = '{5'd12, 1'b1, 5'd7,  3, 1'b1};
        vecs[7] = '{5'd5,  1'b1, 5'd31, 3, 1'b1};

        reset = 1'b0; enable = 1'b0; single = 1'b0; period = 8'd0;
        rdEn = 1'b0; clearFlags = 1'b0;
        ref_reset();
        tick();
        tick();
        chk("reset nStartCnv", int'(nStartCnv), 1);
        chk("reset rdData", int'(rdData), 0);
        chk("reset count", int'(count), 0);
        chk("reset empty", int'(empty), 1);
        chk("reset full", int'(full), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset timeout", int'(timeout), 0);
        reset = 1'b1;
        tick();

        // Single conversion with a slow converter.
        cv_rise = 2; cv_len = 18;
        load(5'd22);
        pulse_single();
        wait_for("single start", W_NSTART, 0, 5);
        wait_for("single push", W_COUNT, 1, 40);
        chk("single count", int'(count), 1);
        wait_for("single idle", W_IDLE, 0, 5);
        rdEn = 1'b1; tick(); rdEn = 1'b0;
        chk("single rdData", int'(rdData), 22);
        chk("single empty", int'(empty), 1);

        // Vector table of single-shot conversions with optional pops.
        cv_rise = 1; cv_len = 2;
        for (int i = 0; i < 8; i++) begin
            load(vecs[i].data);
            pulse_single();
            wait_for($sformatf("tbl[%0d] start", i), W_NSTART, 0, 10);
            wait_for($sformatf("tbl[%0d] idle", i), W_IDLE, 0, 40);
            if (vecs[i].pop) begin
                rdEn = 1'b1; tick(); rdEn = 1'b0;
            end
            chk($sformatf("tbl[%0d] rdData", i), int'(rdData), int'(vecs[i].exp_rd));
            chk($sformatf("tbl[%0d] count", i), int'(count), vecs[i].exp_cnt);
            chk($sformatf("tbl[%0d] overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
        end
        rdEn = 1'b1; repeat (4) tick(); rdEn = 1'b0;
        chk("empty pop holds rdData", int'(rdData), 5);
        clearFlags = 1'b1; tick(); clearFlags = 1'b0;
        chk("clear overflow", int'(overflow), 0);

        // Continuous mode overruns the FIFO.
        cv_rise = 1; cv_len = 3; period = 8'd3;
        for (int v = 1; v <= 5; v++) load(5'(v));
        enable = 1'b1;
        wait_for("cont overflow", W_OVF, 0, 200);
        enable = 1'b0;
        wait_for("cont idle", W_IDLE, 0, 20);
        chk("cont full", int'(full), 1);
        chk("cont count", int'(count), 4);
        chk("cont overflow", int'(overflow), 1);
        rdEn = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            tick();
            chk($sformatf("cont read %0d", v), int'(rdData), v);
        end
        rdEn = 1'b0;
        clearFlags = 1'b1; tick(); clearFlags = 1'b0;

        // Push and pop on the same edge while full.
        period = 8'd2;
        load(5'd10); load(5'd11); load(5'd12); load(5'd13); load(5'd9);
        enable = 1'b1;
        wait_for("fill 4", W_COUNT, 4, 200);
        tag0 = push_tag;
        n = 0;
        while (push_tag == tag0 && n < 60) begin
            tick();
            #3;
            n++;
        end
        chk("fifth result seen", int'(push_tag != tag0), 1);
        enable = 1'b0;
        rdEn = 1'b1; tick(); rdEn = 1'b0;
        chk("pushpop count", int'(count), 4);
        chk("pushpop overflow", int'(overflow), 0);
        chk("pushpop rdData", int'(rdData), 10);
        exp4[0] = 5'd11; exp4[1] = 5'd12; exp4[2] = 5'd13; exp4[3] = 5'd9;
        rdEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("pushpop read %0d", i + 2), int'(rdData), int'(exp4[i]));
        end
        rdEn = 1'b0;
        wait_for("pushpop idle", W_IDLE, 0, 20);

        // Converter never answers.
        cv_dead = 1'b1;
        pulse_single();
        wait_for("to start", W_NSTART, 0, 5);
        repeat (TIMEOUT - 1) tick();
        chk("to before timeout", int'(timeout), 0);
        chk("to before nStartCnv", int'(nStartCnv), 0);
        tick();
        chk("to timeout", int'(timeout), 1);
        chk("to nStartCnv", int'(nStartCnv), 1);
        chk("to count", int'(count), 0);
        wait_for("to idle", W_IDLE, 0, 20);
        clearFlags = 1'b1; tick(); clearFlags = 1'b0;
        chk("to clear", int'(timeout), 0);
        cv_dead = 1'b0;

        // Enable dropped during sBusy.
        cv_rise = 1; cv_len = 8; period = 8'd5;
        enable = 1'b1;
        wait_for("drop start", W_NSTART, 0, 10);
        wait_for("drop busy", W_NSTART, 1, 10);
        enable = 1'b0;
        wait_for("drop push", W_COUNT, 1, 20);
        repeat (5) tick();
        chk("drop busy in gap", int'(busy), 1);
        tick();
        chk("drop busy after gap", int'(busy), 0);
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (nStartCnv !== 1'b1) ok = 1'b0;
        end
        chk("drop no restart", int'(ok), 1);
        rdEn = 1'b1; tick(); rdEn = 1'b0;

        // Asynchronous reset in sBusy with two entries stored.
        cv_rise = 1; cv_len = 6; period = 8'd1;
        enable = 1'b1;
        wait_for("rst fill", W_COUNT, 2, 100);
        wait_for("rst start", W_NSTART, 0, 20);
        wait_for("rst busy", W_NSTART, 1, 20);
        #1;
        reset = 1'b0;
        ref_reset();
        #1;
        chk("rst nStartCnv", int'(nStartCnv), 1);
        chk("rst count", int'(count), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst busy", int'(busy), 0);
        enable = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("rst no push on release", int'(count), 0);

        // Randomized traffic against the queue reference.
        cv_rise = 0; cv_len = 0;
        for (int i = 0; i < 600; i++) begin
            rdEn       = ($urandom_range(0, 2) == 0);
            clearFlags = ($urandom_range(0, 24) == 0);
            single     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) period = 8'($urandom_range(0, 4));
            tick();
        end
        enable = 1'b0; single = 1'b0; rdEn = 1'b0; clearFlags = 1'b0;
        repeat (40) tick();
        wait_for("random idle", W_IDLE, 0, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/saradc_host.md
SARADC_HOST -- requirements
Module: saradc_host

Interface
REQ-001 Parameter DEPTH, default 4, capture FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 40, maximum cycles spent in sStart or in sBusy before abort (1..255).
REQ-003 clock  in  1  single rising-edge clock shared with the SAR converter.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  continuous mode: when high, run back-to-back conversions separated by period cycles.
REQ-006 single  in  1  one-cycle pulse requesting exactly one conversion.
REQ-007 period  in  8  idle gap in cycles between conversions in continuous mode.
REQ-008 nEndCnv  in  1  converter status: high while converting, falls when the result is valid.
REQ-009 dataIn  in  5  converter result; valid at and after the cycle nEndCnv is sampled low in sBusy.
REQ-010 nStartCnv  out  1  active-low start request to the converter.
REQ-011 rdEn  in  1  FIFO pop request.
REQ-012 rdData  out  5  registered FIFO head output.
REQ-013 empty, full  out  1 each  FIFO status flags.
REQ-014 count  out  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-015 busy  out  1  high in every state except sIdle.
REQ-016 overflow, timeout  out  1 each  sticky error flags.
REQ-017 clearFlags  in  1  synchronous clear of overflow and timeout.

Function
REQ-018 States: sIdle, sStart, sBusy, sGap; all transitions on the rising clock edge.
REQ-019 single sets a pending bit; pending clears on entry to sStart; single pulses outside sIdle are retained, not lost.
REQ-020 sIdle: if enable or pending -> sStart; nStartCnv goes 0 on that same edge.
REQ-021 sStart: nStartCnv held 0 until nEndCnv sampled 1 -> sBusy, with nStartCnv returning to 1 on that edge.
REQ-022 sBusy: when nEndCnv is sampled 0 -> push dataIn into FIFO on that edge, then -> sGap.
REQ-023 A shared timer SHALL reset on entry to sStart and to sBusy; on reaching TIMEOUT: timeout=1, nStartCnv=1, no FIFO write, -> sGap.
REQ-024 sGap: down-counter loaded with period; period=0 leaves after one cycle; at zero -> sStart if enable, else sIdle.
REQ-025 enable deasserted mid-conversion: the current conversion completes and is stored, then -> sIdle via sGap.
REQ-026 Push while full and no pop: value dropped, overflow=1, FIFO contents unchanged.
REQ-027 Push and pop in same cycle while full: both performed, count unchanged, no overflow.
REQ-028 Pop while empty: ignored, rdData holds its previous value.
REQ-029 Pop: rdData updated with the head entry on the edge rdEn&&!empty is sampled (one-cycle latency); FIFO order strictly first-in-first-out with pointer wrap-around modulo DEPTH.
REQ-030 clearFlags has priority over simultaneous flag set (clear wins in that cycle).

Reset
REQ-031 reset low immediately forces state=sIdle, nStartCnv=1, rdData=0, count=0, empty=1, full=0, busy=0, overflow=0, timeout=0, pending=0, timer and gap counter=0.
REQ-032 Reset mid-operation discards any in-flight conversion and all FIFO contents; no push occurs on release.

Verification
REQ-033 Reset mid-sBusy with 2 entries stored -> nStartCnv=1, count=0, empty=1, busy=0 with no clock edge required.
REQ-034 single pulse, converter model raises nEndCnv 2 cycles later and drops it 18 cycles later with dataIn=5'b10110 -> count=1; rdEn -> rdData=22, empty=1.
REQ-035 enable=1, period=3, results 1,2,3,4,5, no reads -> full=1, count=4, overflow=1, reads return 1,2,3,4.
REQ-036 converter model never raises nEndCnv -> after 40 cycles timeout=1, nStartCnv=1, count=0; clearFlags -> timeout=0.
REQ-037 FIFO full, rdEn asserted on the push cycle with dataIn=9 -> count stays 4, overflow=0, the fifth read returns 9.
REQ-038 enable dropped during sBusy -> result stored, busy=0 after period+1 cycles, no further nStartCnv low.
